// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
// The generator takes the master side; pixel pipeline and output stage take slave.
interface vga_timing_gen_if #(
    parameter int PX_W = 10
);
    logic            i_enable;
    logic            o_hs;
    logic            o_vs;
    logic            o_de;
    logic [PX_W-1:0] o_px;
    logic [PX_W-1:0] o_py;
    logic            o_line_start;
    logic            o_frame_start;
    logic            o_hs_d;
    logic            o_vs_d;
    logic            o_de_d;

    modport master (
        input  i_enable,
        output o_hs, o_vs, o_de, o_px, o_py,
        output o_line_start, o_frame_start,
        output o_hs_d, o_vs_d, o_de_d
    );

    modport slave (
        output i_enable,
        input  o_hs, o_vs, o_de, o_px, o_py,
        input  o_line_start, o_frame_start,
        input  o_hs_d, o_vs_d, o_de_d
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable, line/frame
// strobes and a delay line aligning sync/DE with downstream pixel latency.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CNT_W      = 11,
    parameter int PX_W       = 10,
    parameter int PIPE_DELAY = 0
) (
    input logic              i_clk,
    input logic              i_reset,
    vga_timing_gen_if.master tim
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_A0    = H_SYNC + H_BP;
    localparam int H_A1    = H_A0 + H_ACTIVE;
    localparam int V_A0    = V_SYNC + V_BP;
    localparam int V_A1    = V_A0 + V_ACTIVE;
    localparam int CW1     = CNT_W + 1;

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) ||
        H_ACTIVE > (1 << PX_W) || V_ACTIVE > (1 << PX_W) ||
        PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_param_err
        $error("vga_timing_gen: illegal parameter combination");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    logic             hs_n;
    logic             vs_n;
    logic             h_act;
    logic             v_act;
    logic             de_n;
    logic [PX_W-1:0]  px_n;
    logic [PX_W-1:0]  py_n;
    logic             ls_n;
    logic             fs_n;

    logic             hs;
    logic             vs;
    logic             de;
    logic [PX_W-1:0]  px;
    logic [PX_W-1:0]  py;
    logic             ls;
    logic             fs;

    assign h_wrap = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_wrap = (v_cnt == CNT_W'(V_TOTAL - 1));

    // Raster position; v advances on the very edge h wraps.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tim.i_enable) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end
        end
    end

    // Decode the current position into next stage-1 levels and coordinates.
    always_comb begin
        hs_n  = ({1'b0, h_cnt} < CW1'(H_SYNC)) ? HS_POL : !HS_POL;
        vs_n  = ({1'b0, v_cnt} < CW1'(V_SYNC)) ? VS_POL : !VS_POL;
        h_act = ({1'b0, h_cnt} >= CW1'(H_A0)) &&
                ({1'b0, h_cnt} <  CW1'(H_A1));
        v_act = ({1'b0, v_cnt} >= CW1'(V_A0)) &&
                ({1'b0, v_cnt} <  CW1'(V_A1));
        de_n  = h_act & v_act;
        px_n  = de_n ? PX_W'(h_cnt - CNT_W'(H_A0)) : '0;
        py_n  = de_n ? PX_W'(v_cnt - CNT_W'(V_A0)) : '0;
        ls_n  = de_n & (px_n == '0);
        fs_n  = ls_n & (py_n == '0);
    end

    // Stage-1 registers; strobes clear on idle edges so they never repeat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hs <= !HS_POL;
            vs <= !VS_POL;
            de <= 1'b0;
            px <= '0;
            py <= '0;
            ls <= 1'b0;
            fs <= 1'b0;
        end else begin
            ls <= 1'b0;
            fs <= 1'b0;
            if (tim.i_enable) begin
                hs <= hs_n;
                vs <= vs_n;
                de <= de_n;
                px <= px_n;
                py <= py_n;
                ls <= ls_n;
                fs <= fs_n;
            end
        end
    end

    assign tim.o_hs          = hs;
    assign tim.o_vs          = vs;
    assign tim.o_de          = de;
    assign tim.o_px          = px;
    assign tim.o_py          = py;
    assign tim.o_line_start  = ls;
    assign tim.o_frame_start = fs;

    if (PIPE_DELAY == 0) begin : g_no_dly
        assign tim.o_hs_d = hs;
        assign tim.o_vs_d = vs;
        assign tim.o_de_d = de;
    end else begin : g_dly
        logic [2:0] dly [PIPE_DELAY];

        // Shift {hs, vs, de} one slot per enabled edge.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    dly[i] <= {!HS_POL, !VS_POL, 1'b0};
                end
            end else if (tim.i_enable) begin
                dly[0] <= {hs, vs, de};
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    dly[i] <= dly[i-1];
                end
            end
        end

        assign tim.o_hs_d = dly[PIPE_DELAY-1][2];
        assign tim.o_vs_d = dly[PIPE_DELAY-1][1];
        assign tim.o_de_d = dly[PIPE_DELAY-1][0];
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator. It is the successor to the fixed 640x480 sync generator and feeds the pixel pipeline and the VGA output stage. It generalises counter and coordinate widths and sync polarity. It adds a pixel clock-enable, line/frame-start strobes, and a configurable delay line that aligns the sync and DE outputs with downstream pixel latency.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CNT_W, 11, internal h/v counter width
PX_W, 10, coordinate output width
PIPE_DELAY, 0, extra enabled-cycle delay on the delayed outputs (0..15)

Ports:
i_clk  in  1  pixel clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  pixel clock-enable; all state advances only when high
o_hs  out  1  horizontal sync, stage-1 timing
o_vs  out  1  vertical sync, stage-1 timing
o_de  out  1  active-area flag, stage-1 timing
o_px  out  PX_W  pixel x (0 outside active area)
o_py  out  PX_W  pixel y (0 outside active area)
o_line_start  out  1  pulse with px=0 of every active line
o_frame_start  out  1  pulse with px=0,py=0
o_hs_d  out  1  o_hs delayed PIPE_DELAY enabled cycles
o_vs_d  out  1  o_vs delayed PIPE_DELAY enabled cycles
o_de_d  out  1  o_de delayed PIPE_DELAY enabled cycles

Behaviour:
- Derived values: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL likewise. Line order is sync, back porch, active, front porch. The vertical order is the same.
- Elaboration check: an error is raised if H_TOTAL or V_TOTAL exceeds 2^CNT_W, if H_ACTIVE or V_ACTIVE exceeds 2^PX_W, or if PIPE_DELAY > 15.
- Reset (sync, has priority over i_enable):
  - h_cnt and v_cnt go to 0.
  - o_hs, o_vs, o_hs_d and o_vs_d go to the inactive level (!HS_POL / !VS_POL).
  - o_de, o_de_d, the strobes, o_px and o_py go to 0.
  - The whole delay line is filled with inactive values.
- Counting, on each edge with i_enable=1:
  - h_cnt increments. It wraps from H_TOTAL-1 to 0.
  - v_cnt increments on the same edge that h_cnt wraps, with no lag cycle. It wraps from V_TOTAL-1 to 0.
- Stage-1 outputs are registered and reflect the counter value held before the edge (latency 1):
  - o_hs = HS_POL when h_cnt < H_SYNC, else !HS_POL. o_vs is defined the same way on v_cnt.
  - h_act = H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE. v_act uses the same rule on v_cnt.
  - o_de = h_act & v_act.
  - o_px = h_cnt-(H_SYNC+H_BP) when o_de, else 0. o_py = v_cnt-(V_SYNC+V_BP) when o_de, else 0.
  - Subtractions are done at CNT_W width and truncated to PX_W.
  - o_line_start = o_de & (px==0). o_frame_start = o_line_start & (py==0).
- i_enable=0:
  - Counters, stage-1 levels, coordinates and the delay line hold.
  - o_line_start and o_frame_start are forced to 0 on that edge, so a strobe is never repeated.
- Delay line: a shift register of depth PIPE_DELAY on {hs, vs, de}.
  - It shifts only when i_enable=1.
  - PIPE_DELAY=0 means the _d outputs equal the stage-1 outputs combinationally.
- Reset mid-line or mid-frame restarts the raster at h=0, v=0 on the next enabled edge, with no partial strobes.

Test Plan:
- Defaults, enable tied high, reset released → o_hs is active (0) for 96 of every 800 cycles. o_vs is active (0) for exactly 1600 cycles per 420000-cycle frame.
- Defaults → the first o_de=1 appears on the 28145th enabled edge after reset, with o_px=0, o_py=0 and o_frame_start=1. o_de is high for 640 consecutive cycles with o_px 0..639, and 307200 o_de cycles per frame.
- Defaults → o_line_start pulses 480 times per frame. The last pulse has o_py=479. o_frame_start pulses exactly once per frame.
- HS_POL=1, VS_POL=1, PIPE_DELAY=3 → sync levels are inverted vs the default. o_hs_d, o_vs_d and o_de_d equal o_hs, o_vs and o_de three edges earlier. During reset they read 0, 0, 0.
- Toggle i_enable 1/0 every cycle → raster period doubles to 1600 clocks per line. Strobes stay single-cycle. Coordinates hold while disabled.
- Assert i_reset at h=500, v=200 for one cycle → all outputs reach reset values next edge. The raster restarts, and the first o_de is again 28145 enabled edges later.
